// File: rtl/tlp_rx_hdr_parser_if.sv
// ---------------------------------------------------------------------------
// tlp_rx_hdr_parser_if
//   Bundles every stream/handshake signal of the RX TLP header parser.
//   Signal groups:
//     input stream   : in_dw[31:0] (byte 0 in [31:24]), in_valid, in_sop, in_eop, in_ready
//     header output  : hdr_valid/hdr_ready plus decoded DW0..DW3 fields
//     payload stream : pl_dw[31:0], pl_valid, pl_last, pl_ready
//     errors         : err_malformed, err_tag (one-cycle pulses)
//   Modports:
//     master : the parser itself (drives in_ready, hdr_*, pl_*, err_*)
//     slave  : the surrounding logic (drives the input stream, hdr_ready, pl_ready)
// ---------------------------------------------------------------------------
interface tlp_rx_hdr_parser_if;
    logic [31:0] in_dw;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_ready;

    logic        hdr_valid;
    logic        hdr_ready;
    logic [2:0]  hdr_fmt;
    logic [4:0]  hdr_type;
    logic [2:0]  hdr_tc;
    logic [2:0]  hdr_attr;
    logic        hdr_th;
    logic        hdr_td;
    logic        hdr_ep;
    logic [1:0]  hdr_at;
    logic [9:0]  hdr_length;
    logic [15:0] hdr_req_id;
    logic [9:0]  hdr_tag;
    logic [3:0]  hdr_first_be;
    logic [3:0]  hdr_last_be;
    logic [63:0] hdr_address;
    logic [15:0] hdr_cpl_id;
    logic [2:0]  hdr_cpl_status;
    logic        hdr_bcm;
    logic [11:0] hdr_byte_count;
    logic [6:0]  hdr_lower_addr;
    logic [7:0]  hdr_msg_code;

    logic [31:0] pl_dw;
    logic        pl_valid;
    logic        pl_last;
    logic        pl_ready;

    logic        err_malformed;
    logic        err_tag;

    modport master (
        input  in_dw, in_valid, in_sop, in_eop, hdr_ready, pl_ready,
        output in_ready, hdr_valid, hdr_fmt, hdr_type, hdr_tc, hdr_attr, hdr_th, hdr_td,
               hdr_ep, hdr_at, hdr_length, hdr_req_id, hdr_tag, hdr_first_be, hdr_last_be,
               hdr_address, hdr_cpl_id, hdr_cpl_status, hdr_bcm, hdr_byte_count,
               hdr_lower_addr, hdr_msg_code, pl_dw, pl_valid, pl_last, err_malformed, err_tag
    );

    modport slave (
        output in_dw, in_valid, in_sop, in_eop, hdr_ready, pl_ready,
        input  in_ready, hdr_valid, hdr_fmt, hdr_type, hdr_tc, hdr_attr, hdr_th, hdr_td,
               hdr_ep, hdr_at, hdr_length, hdr_req_id, hdr_tag, hdr_first_be, hdr_last_be,
               hdr_address, hdr_cpl_id, hdr_cpl_status, hdr_bcm, hdr_byte_count,
               hdr_lower_addr, hdr_msg_code, pl_dw, pl_valid, pl_last, err_malformed, err_tag
    );
endinterface

// File: rtl/tlp_rx_hdr_parser.sv
// ---------------------------------------------------------------------------
// tlp_rx_hdr_parser
//   Receive-side TLP header parser. Takes a 32-bit DW stream framed by
//   sop/eop, captures DW0..DW3, presents the decoded header with a
//   valid/ready handshake, passes the payload through and drops the ECRC DW.
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : tlp_rx_hdr_parser_if.master (input stream, header, payload, errors)
//   Parameters:
//     SUPPORT_10BIT_TAG : 0 -> T9/T8 must be zero (err_tag, forced 0 on output)
//     MAX_PAYLOAD_DW    : largest legal Length for TLPs carrying data
// ---------------------------------------------------------------------------
module tlp_rx_hdr_parser #(
    parameter bit SUPPORT_10BIT_TAG = 1'b0,
    parameter int MAX_PAYLOAD_DW    = 256
) (
    input logic               clk,
    input logic               rst_n,
    tlp_rx_hdr_parser_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_HOLD,
        ST_PAYLOAD,
        ST_ECRC,
        ST_DROP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] dw0_reg, dw0_next;
    logic [31:0] dw1_reg, dw1_next;
    logic [31:0] dw2_reg, dw2_next;
    logic [31:0] dw3_reg, dw3_next;
    logic [9:0]  cnt_reg, cnt_next;
    logic        drop_pend_reg, drop_pend_next;
    logic        err_mal_reg, err_mal_next;
    logic        err_tag_reg, err_tag_next;

    logic        in_ready_c;
    logic        xfer;
    logic        pl_valid_c;
    logic        pl_last_c;
    logic [31:0] pl_dw_c;

    // Decode of the latched DW0 that steers the sequence
    logic fmt_data, fmt_4dw, td_bit, tag_bad;
    assign fmt_data = dw0_reg[30];
    assign fmt_4dw  = dw0_reg[29];
    assign td_bit   = dw0_reg[15];
    assign tag_bad  = !SUPPORT_10BIT_TAG && (dw0_reg[23] | dw0_reg[19]);

    // Length check done on the incoming DW0 itself so an oversized TLP never
    // gets its header presented. Length 0 encodes 1024 DW.
    logic [10:0] in_len_dw;
    logic        in_len_bad;
    assign in_len_dw  = (bus.in_dw[9:0] == 10'd0) ? 11'd1024 : {1'b0, bus.in_dw[9:0]};
    assign in_len_bad = bus.in_dw[30] && (in_len_dw > 11'(MAX_PAYLOAD_DW));

    // Position of the current header/payload DW relative to the expected end
    logic hdr_last, hdr_exp_eop, cnt_last, pl_exp_eop;
    assign hdr_last    = ((state_reg == ST_HDR2) && !fmt_4dw) || (state_reg == ST_HDR3);
    assign hdr_exp_eop = hdr_last && !fmt_data && !td_bit;
    assign cnt_last    = (cnt_reg == 10'd1);
    assign pl_exp_eop  = cnt_last && !td_bit;

    // in_ready depends on state only (plus pl_ready in pass-through) and is
    // forced low while reset is held.
    always_comb begin
        in_ready_c = 1'b0;
        case (state_reg)
            ST_IDLE, ST_HDR1, ST_HDR2, ST_HDR3, ST_ECRC, ST_DROP: in_ready_c = 1'b1;
            ST_PAYLOAD: in_ready_c = bus.pl_ready;
            default:    in_ready_c = 1'b0;
        endcase
        in_ready_c = in_ready_c & rst_n;
    end

    assign xfer = bus.in_valid & in_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            dw0_reg       <= '0;
            dw1_reg       <= '0;
            dw2_reg       <= '0;
            dw3_reg       <= '0;
            cnt_reg       <= '0;
            drop_pend_reg <= 1'b0;
            err_mal_reg   <= 1'b0;
            err_tag_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dw0_reg       <= dw0_next;
            dw1_reg       <= dw1_next;
            dw2_reg       <= dw2_next;
            dw3_reg       <= dw3_next;
            cnt_reg       <= cnt_next;
            drop_pend_reg <= drop_pend_next;
            err_mal_reg   <= err_mal_next;
            err_tag_reg   <= err_tag_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dw0_next       = dw0_reg;
        dw1_next       = dw1_reg;
        dw2_next       = dw2_reg;
        dw3_next       = dw3_reg;
        cnt_next       = cnt_reg;
        drop_pend_next = drop_pend_reg;
        err_mal_next   = 1'b0;
        err_tag_next   = 1'b0;
        pl_valid_c     = 1'b0;
        pl_last_c      = 1'b0;
        pl_dw_c        = '0;

        case (state_reg)
            ST_IDLE: begin
                // Non-sop DWs here are leftovers of an aborted TLP: ignored.
                if (xfer && bus.in_sop) begin
                    dw0_next       = bus.in_dw;
                    dw1_next       = '0;
                    dw2_next       = '0;
                    dw3_next       = '0;
                    cnt_next       = bus.in_dw[9:0];
                    drop_pend_next = 1'b0;
                    if (bus.in_eop) begin
                        err_mal_next = 1'b1;
                    end else if (in_len_bad) begin
                        err_mal_next = 1'b1;
                        state_next   = ST_DROP;
                    end else begin
                        state_next   = ST_HDR1;
                    end
                end
            end

            ST_HDR1, ST_HDR2, ST_HDR3: begin
                if (xfer) begin
                    case (state_reg)
                        ST_HDR1: dw1_next = bus.in_dw;
                        ST_HDR2: dw2_next = bus.in_dw;
                        default: dw3_next = bus.in_dw;
                    endcase
                    if (bus.in_eop) begin
                        // eop closes the packet either way; only a clean
                        // end-of-header lets the header through.
                        if (hdr_exp_eop && !bus.in_sop) begin
                            state_next = ST_HOLD;
                        end else begin
                            err_mal_next = 1'b1;
                            state_next   = ST_IDLE;
                        end
                    end else if (bus.in_sop) begin
                        err_mal_next = 1'b1;
                        state_next   = ST_DROP;
                    end else if (hdr_last) begin
                        // Missing eop: still present the header, then drain
                        // the rest of the packet.
                        state_next = ST_HOLD;
                        if (hdr_exp_eop) begin
                            err_mal_next   = 1'b1;
                            drop_pend_next = 1'b1;
                        end
                    end else begin
                        state_next = (state_reg == ST_HDR1) ? ST_HDR2 : ST_HDR3;
                    end
                    if (state_next == ST_HOLD) begin
                        err_tag_next = tag_bad;
                    end
                end
            end

            ST_HOLD: begin
                if (bus.hdr_ready) begin
                    if (drop_pend_reg) begin
                        state_next = ST_DROP;
                    end else if (fmt_data) begin
                        state_next = ST_PAYLOAD;
                    end else if (td_bit) begin
                        state_next = ST_ECRC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_PAYLOAD: begin
                pl_valid_c = bus.in_valid;
                pl_dw_c    = bus.in_dw;
                pl_last_c  = cnt_last | bus.in_eop;
                if (xfer) begin
                    cnt_next = cnt_reg - 10'd1;
                    if (bus.in_eop) begin
                        err_mal_next = !pl_exp_eop || bus.in_sop;
                        state_next   = ST_IDLE;
                    end else if (bus.in_sop || pl_exp_eop) begin
                        err_mal_next = 1'b1;
                        state_next   = ST_DROP;
                    end else if (cnt_last) begin
                        state_next = ST_ECRC;
                    end
                end
            end

            ST_ECRC: begin
                if (xfer) begin
                    if (bus.in_eop) begin
                        err_mal_next = bus.in_sop;
                        state_next   = ST_IDLE;
                    end else begin
                        err_mal_next = 1'b1;
                        state_next   = ST_DROP;
                    end
                end
            end

            ST_DROP: begin
                if (xfer && bus.in_eop) begin
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Completions carry Requester ID / Tag in DW2 instead of DW1.
    logic is_cpl;
    assign is_cpl = (dw0_reg[28:25] == 4'b0101);

    assign bus.in_ready       = in_ready_c;
    assign bus.hdr_valid      = (state_reg == ST_HOLD);
    assign bus.hdr_fmt        = dw0_reg[31:29];
    assign bus.hdr_type       = dw0_reg[28:24];
    assign bus.hdr_tc         = dw0_reg[22:20];
    assign bus.hdr_attr       = {dw0_reg[18], dw0_reg[13:12]};
    assign bus.hdr_th         = dw0_reg[16];
    assign bus.hdr_td         = dw0_reg[15];
    assign bus.hdr_ep         = dw0_reg[14];
    assign bus.hdr_at         = dw0_reg[11:10];
    assign bus.hdr_length     = dw0_reg[9:0];
    assign bus.hdr_req_id     = is_cpl ? dw2_reg[31:16] : dw1_reg[31:16];
    assign bus.hdr_tag[7:0]   = is_cpl ? dw2_reg[15:8] : dw1_reg[15:8];
    assign bus.hdr_tag[9:8]   = SUPPORT_10BIT_TAG ? {dw0_reg[23], dw0_reg[19]} : 2'b00;
    assign bus.hdr_first_be   = dw1_reg[3:0];
    assign bus.hdr_last_be    = dw1_reg[7:4];
    assign bus.hdr_address    = fmt_4dw ? {dw2_reg, dw3_reg[31:2], 2'b00}
                                        : {32'b0, dw2_reg[31:2], 2'b00};
    assign bus.hdr_cpl_id     = dw1_reg[31:16];
    assign bus.hdr_cpl_status = dw1_reg[15:13];
    assign bus.hdr_bcm        = dw1_reg[12];
    assign bus.hdr_byte_count = dw1_reg[11:0];
    assign bus.hdr_lower_addr = dw2_reg[6:0];
    assign bus.hdr_msg_code   = dw1_reg[7:0];
    assign bus.pl_dw          = pl_dw_c;
    assign bus.pl_valid       = pl_valid_c;
    assign bus.pl_last        = pl_last_c;
    assign bus.err_malformed  = err_mal_reg;
    assign bus.err_tag        = err_tag_reg;

    // LN bit, the reserved bit below the Tag in completions and the low
    // address bits of DW3 carry no decoded meaning here.
    logic unused_bits;
    assign unused_bits = ^{dw0_reg[17], dw2_reg[7], dw3_reg[1:0]};

endmodule

// File: tb/tb_tlp_rx_hdr_parser.sv
module tb_tlp_rx_hdr_parser;

    logic clk = 1'b0;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;

    logic        pl_v_s;
    logic        pl_l_s;
    logic [31:0] pl_dw_s;

    tlp_rx_hdr_parser_if bus ();

    tlp_rx_hdr_parser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one DW; returns #1 after the transferring edge. Payload outputs
    // are sampled on the negedge just before the transfer.
    task automatic send_dw(input logic [31:0] dw, input logic sop, input logic eop);
        int n = 0;
        bus.in_dw    = dw;
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            tests++;
            failed++;
            $error("FAIL send_timeout: observed in_ready 0 expected 1 for dw %0h", dw);
        end
        pl_v_s  = bus.pl_valid;
        pl_l_s  = bus.pl_last;
        pl_dw_s = bus.pl_dw;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic accept_hdr();
        bus.hdr_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.hdr_ready = 1'b0;
    endtask

    // MRd32 Length 1, requester 0x0100, BE F/0
    task automatic mrd_check(input string name, input logic [7:0] tag, input logic [31:0] addr);
        logic [31:0] dw1;
        dw1 = {16'h0100, tag, 8'h0F};
        send_dw(32'h0000_0001, 1'b1, 1'b0);
        send_dw(dw1, 1'b0, 1'b0);
        send_dw(addr, 1'b0, 1'b1);
        chk({name, "_hdr_valid"}, bus.hdr_valid, 1);
        chk({name, "_tag"}, bus.hdr_tag, {2'b00, tag});
        chk({name, "_addr"}, bus.hdr_address, {32'b0, addr});
        accept_hdr();
        chk({name, "_released"}, bus.hdr_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lasts;
        int bad;
        bus.in_dw     = '0;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.hdr_ready = 1'b0;
        bus.pl_ready  = 1'b1;
        rst_n         = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_hdr_valid", bus.hdr_valid, 0);
        chk("rst_pl_valid", bus.pl_valid, 0);
        chk("rst_pl_last", bus.pl_last, 0);
        chk("rst_err_mal", bus.err_malformed, 0);
        chk("rst_err_tag", bus.err_tag, 0);
        chk("rst_addr", bus.hdr_address, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        // ---- MRd32 ----
        send_dw(32'h0000_0001, 1'b1, 1'b0);
        send_dw(32'h0100_0A0F, 1'b0, 1'b0);
        chk("mrd_no_early_hdr", bus.hdr_valid, 0);
        send_dw(32'h8000_1004, 1'b0, 1'b1);
        chk("mrd_hdr_valid", bus.hdr_valid, 1);
        chk("mrd_in_ready_hold", bus.in_ready, 0);
        chk("mrd_fmt", bus.hdr_fmt, 0);
        chk("mrd_length", bus.hdr_length, 1);
        chk("mrd_req_id", bus.hdr_req_id, 16'h0100);
        chk("mrd_tag", bus.hdr_tag, 10'h00A);
        chk("mrd_addr", bus.hdr_address, 64'h8000_1004);
        chk("mrd_first_be", bus.hdr_first_be, 4'hF);
        chk("mrd_last_be", bus.hdr_last_be, 4'h0);
        chk("mrd_no_pl", pl_v_s, 0);
        chk("mrd_err_mal", bus.err_malformed, 0);
        accept_hdr();
        chk("mrd_hdr_released", bus.hdr_valid, 0);
        chk("mrd_back_idle", bus.in_ready, 1);

        // ---- MWr64 Len=2 with header back-pressure ----
        send_dw(32'h6000_0002, 1'b1, 1'b0);
        send_dw(32'h0200_05FF, 1'b0, 1'b0);
        send_dw(32'h0000_0001, 1'b0, 1'b0);
        send_dw(32'h2345_6780, 1'b0, 1'b0);
        chk("mwr64_hdr_valid", bus.hdr_valid, 1);
        chk("mwr64_fmt", bus.hdr_fmt, 3);
        chk("mwr64_addr", bus.hdr_address, 64'h1_2345_6780);
        chk("mwr64_length", bus.hdr_length, 2);
        bus.in_dw    = 32'hAAAA_0001;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mwr64_hold_in_ready", bus.in_ready, 0);
            chk("mwr64_hold_hdr_valid", bus.hdr_valid, 1);
        end
        bus.hdr_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.hdr_ready = 1'b0;
        send_dw(32'hAAAA_0001, 1'b0, 1'b0);
        chk("mwr64_pl0_valid", pl_v_s, 1);
        chk("mwr64_pl0_dw", pl_dw_s, 32'hAAAA_0001);
        chk("mwr64_pl0_last", pl_l_s, 0);
        send_dw(32'hBBBB_0002, 1'b0, 1'b1);
        chk("mwr64_pl1_dw", pl_dw_s, 32'hBBBB_0002);
        chk("mwr64_pl1_last", pl_l_s, 1);
        chk("mwr64_err_mal", bus.err_malformed, 0);
        chk("mwr64_idle", bus.in_ready, 1);

        // ---- CplD with T8 set, 8-bit tag only ----
        send_dw(32'h4A08_0001, 1'b1, 1'b0);
        send_dw(32'h0300_0004, 1'b0, 1'b0);
        send_dw(32'h0100_0704, 1'b0, 1'b0);
        chk("cpl_hdr_valid", bus.hdr_valid, 1);
        chk("cpl_err_tag", bus.err_tag, 1);
        chk("cpl_tag", bus.hdr_tag, 10'h007);
        chk("cpl_req_id", bus.hdr_req_id, 16'h0100);
        chk("cpl_cpl_id", bus.hdr_cpl_id, 16'h0300);
        chk("cpl_status", bus.hdr_cpl_status, 0);
        chk("cpl_byte_count", bus.hdr_byte_count, 4);
        chk("cpl_lower_addr", bus.hdr_lower_addr, 4);
        accept_hdr();
        chk("cpl_err_tag_pulse", bus.err_tag, 0);
        send_dw(32'hCAFE_F00D, 1'b0, 1'b1);
        chk("cpl_pl_dw", pl_dw_s, 32'hCAFE_F00D);
        chk("cpl_pl_last", pl_l_s, 1);
        chk("cpl_err_mal", bus.err_malformed, 0);

        // ---- MWr32 Len=4, eop early on payload DW2 ----
        bus.hdr_ready = 1'b1;
        send_dw(32'h4000_0004, 1'b1, 1'b0);
        send_dw(32'h0100_01FF, 1'b0, 1'b0);
        send_dw(32'h0000_2000, 1'b0, 1'b0);
        send_dw(32'hD000_0000, 1'b0, 1'b0);
        send_dw(32'hD000_0001, 1'b0, 1'b0);
        chk("early_pl1_last", pl_l_s, 0);
        send_dw(32'hD000_0002, 1'b0, 1'b1);
        chk("early_pl2_valid", pl_v_s, 1);
        chk("early_pl2_last", pl_l_s, 1);
        chk("early_err_mal", bus.err_malformed, 1);
        @(posedge clk);
        #1;
        chk("early_err_mal_pulse", bus.err_malformed, 0);
        bus.hdr_ready = 1'b0;
        mrd_check("early_next", 8'h14, 32'h0000_0040);

        // ---- TD=1 MWr32 Len=1 plus ECRC ----
        bus.hdr_ready = 1'b1;
        send_dw(32'h4000_8001, 1'b1, 1'b0);
        send_dw(32'h0100_020F, 1'b0, 1'b0);
        send_dw(32'h0000_3000, 1'b0, 1'b0);
        send_dw(32'h1111_2222, 1'b0, 1'b0);
        chk("ecrc_pl_valid", pl_v_s, 1);
        chk("ecrc_pl_dw", pl_dw_s, 32'h1111_2222);
        chk("ecrc_pl_last", pl_l_s, 1);
        send_dw(32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("ecrc_not_forwarded", pl_v_s, 0);
        chk("ecrc_err_mal", bus.err_malformed, 0);
        chk("ecrc_idle", bus.in_ready, 1);

        // ---- Length 300 > MAX_PAYLOAD_DW ----
        send_dw(32'h4000_012C, 1'b1, 1'b0);
        chk("len300_err_mal", bus.err_malformed, 1);
        send_dw(32'h0100_0000, 1'b0, 1'b0);
        chk("len300_no_hdr", bus.hdr_valid, 0);
        send_dw(32'h0000_4000, 1'b0, 1'b0);
        send_dw(32'h5555_5555, 1'b0, 1'b1);
        chk("len300_no_pl", pl_v_s, 0);
        chk("len300_still_no_hdr", bus.hdr_valid, 0);

        // ---- Length 0 means 1024 DW, also over the limit ----
        send_dw(32'h4000_0000, 1'b1, 1'b0);
        chk("len0_err_mal", bus.err_malformed, 1);
        send_dw(32'h0000_0000, 1'b0, 1'b1);
        chk("len0_no_hdr", bus.hdr_valid, 0);

        // ---- Length 256 exactly (largest legal) ----
        send_dw(32'h4000_0100, 1'b1, 1'b0);
        chk("len256_no_err", bus.err_malformed, 0);
        send_dw(32'h0100_10FF, 1'b0, 1'b0);
        send_dw(32'h0000_8000, 1'b0, 1'b0);
        lasts = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) begin
            send_dw(32'hA500_0000 | 32'(i), 1'b0, (i == 255));
            if (!pl_v_s || pl_dw_s !== (32'hA500_0000 | 32'(i))) bad++;
            if (pl_l_s) lasts++;
        end
        chk("len256_data", bad, 0);
        chk("len256_last_count", lasts, 1);
        chk("len256_last_on_final", pl_l_s, 1);
        chk("len256_err_mal", bus.err_malformed, 0);

        // ---- reset in the middle of a payload ----
        send_dw(32'h4000_0004, 1'b1, 1'b0);
        send_dw(32'h0100_09FF, 1'b0, 1'b0);
        send_dw(32'h0000_5000, 1'b0, 1'b0);
        send_dw(32'hE000_0000, 1'b0, 1'b0);
        bus.in_dw    = 32'hE000_0001;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_pl_valid", bus.pl_valid, 0);
        chk("midrst_hdr_valid", bus.hdr_valid, 0);
        chk("midrst_length", bus.hdr_length, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        send_dw(32'hE000_0001, 1'b0, 1'b0);
        chk("midrst_rest_ignored0", pl_v_s, 0);
        send_dw(32'hE000_0002, 1'b0, 1'b0);
        send_dw(32'hE000_0003, 1'b0, 1'b1);
        chk("midrst_rest_ignored1", pl_v_s, 0);
        chk("midrst_no_hdr", bus.hdr_valid, 0);
        chk("midrst_no_err", bus.err_malformed, 0);
        bus.hdr_ready = 1'b0;
        mrd_check("midrst_next", 8'h33, 32'h0000_1230);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
